// File: rtl/countdown_pkg.sv
// Shared types and sizing helpers for the countdown timer controller.
package countdown_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Counter width able to hold 0 .. div-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/countdown_controller_button_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce filter, and a
// one-cycle pulse on each accepted rising edge.
module button_conditioner
    import countdown_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Any cycle where the synchronized level agrees with the accepted level restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync_b == stable) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                count  <= '0;
                stable <= sync_b;
                pulse  <= sync_b;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_controller.sv
// Countdown timer sequencer: button conditioning, 1 Hz decrement strobe, counter
// enables and alarm. Define ALARM_BLINK_EN to make blink flash while in DONE.
module countdown_controller
    import countdown_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 100000000,
    parameter int unsigned TICK_HZ         = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       set_btn,
    input  logic       start_btn,
    input  logic       count_zero,
    output logic       clear_en,
    output logic       load_en,
    output logic       dec_en,
    output logic       alarm,
    output logic       blink,
    output logic [2:0] state_o
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PW       = cnt_width(TICK_DIV);

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          set_p;
    logic          start_p;
    logic          tick_c;
    logic          done_entry_c;
    logic          done_stay_c;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_btn (
        .clock (clock),
        .reset (reset),
        .raw   (set_btn),
        .pulse (set_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .clock (clock),
        .reset (reset),
        .raw   (start_btn),
        .pulse (start_p)
    );

    assign tick_c       = (prescaler == PW'(TICK_DIV - 1));
    assign done_entry_c = (state == ST_RUN) && !set_p && count_zero;
    assign done_stay_c  = (state == ST_DONE) && !set_p && !start_p;
    assign state_o      = state;

    // Sequencer; set beats start, and expiry beats start while running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            clear_en  <= 1'b1;
            load_en   <= 1'b0;
            dec_en    <= 1'b0;
            alarm     <= 1'b0;
            prescaler <= '0;
        end else begin
            load_en <= 1'b0;
            dec_en  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (set_p) begin
                        state    <= ST_ARMED;
                        load_en  <= 1'b1;
                        clear_en <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (set_p) begin
                        load_en <= 1'b1;
                    end else if (start_p) begin
                        state     <= ST_RUN;
                        prescaler <= '0;
                    end
                end
                ST_RUN: begin
                    if (set_p) begin
                        state   <= ST_ARMED;
                        load_en <= 1'b1;
                    end else if (count_zero) begin
                        state <= ST_DONE;
                        alarm <= 1'b1;
                    end else if (start_p) begin
                        state <= ST_PAUSE;
                    end else begin
                        dec_en    <= tick_c;
                        prescaler <= tick_c ? '0 : prescaler + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (set_p) begin
                        state   <= ST_ARMED;
                        load_en <= 1'b1;
                    end else if (start_p) begin
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (set_p) begin
                        state   <= ST_ARMED;
                        load_en <= 1'b1;
                        alarm   <= 1'b0;
                    end else if (start_p) begin
                        state    <= ST_IDLE;
                        clear_en <= 1'b1;
                        alarm    <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clear_en <= 1'b1;
                    alarm    <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int unsigned BLINK_DIV = (TICK_DIV / 4 < 1) ? 1 : TICK_DIV / 4;
    localparam int unsigned BW        = cnt_width(BLINK_DIV);

    logic [BW-1:0] blink_cnt;

    // Flash phase restarts lit on every DONE entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (done_entry_c) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (done_stay_c) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end else begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end
    end
`else
    // Steady level that tracks alarm.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink <= 1'b0;
        end else begin
            blink <= done_entry_c || done_stay_c;
        end
    end
`endif

endmodule
